// File: rtl/logic_reduce_pkg.sv
// logic_reduce_pkg: shared reduction mode encodings and filter counter width.
// Used by logic_reduce_core (mode decode) and logic_reduce_filt (counter width).
package logic_reduce_pkg;
    localparam int CNT_W = 8;
    typedef enum logic [2:0] {
        RED_AND  = 3'd0,
        RED_NAND = 3'd1,
        RED_OR   = 3'd2,
        RED_NOR  = 3'd3,
        RED_XOR  = 3'd4,
        RED_XNOR = 3'd5
    } red_mode_e;
endpackage

// File: rtl/logic_reduce_core.sv
// logic_reduce_core: combinational reduction of a per-bit-inverted input vector.
// Ports:
//   I     - data inputs, WIDTH bits
//   O_RAW - MODE reduction over (I ^ INV_MASK)
module logic_reduce_core
    import logic_reduce_pkg::*;
#(
    parameter int              WIDTH    = 5,
    parameter logic [WIDTH-1:0] INV_MASK = 5'b00111,
    parameter int              MODE     = 3
) (
    input  logic [WIDTH-1:0] I,
    output logic             O_RAW
);
    localparam red_mode_e M = red_mode_e'(MODE);

    if (MODE < 0 || MODE > 5) begin : g_bad_mode
        $error("logic_reduce_core: MODE %0d is not a legal reduction", MODE);
    end

    logic [WIDTH-1:0] w_x;

    assign w_x   = I ^ INV_MASK;
    assign O_RAW = M == RED_AND  ? &w_x  :
                   M == RED_NAND ? ~&w_x :
                   M == RED_OR   ? |w_x  :
                   M == RED_NOR  ? ~|w_x :
                   M == RED_XOR  ? ^w_x  : ~^w_x;
endmodule

// File: rtl/logic_reduce_filt.sv
// logic_reduce_filt: configurable logic reduction with sampled, persistence-filtered output.
// Ports:
//   C     - clock, rising edge
//   R     - synchronous active-high reset (priority over CE)
//   CE    - clock enable for sample/filter state
//   I     - data inputs, WIDTH bits
//   O_RAW - unregistered reduction result
//   O     - filtered registered result
//   VALID - sample equals O (no change pending)
//   RISE  - one-cycle pulse when O becomes 1
//   FALL  - one-cycle pulse when O becomes 0
// Macro LOGIC_REDUCE_FILT_EDGE_EN: builds RISE/FALL pulse logic; otherwise both are tied 0.
module logic_reduce_filt
    import logic_reduce_pkg::*;
#(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] INV_MASK = 5'b00111,
    parameter int               MODE     = 3,
    parameter int               FILTER   = 0,
    parameter logic             INIT     = 1'b0
) (
    input  logic             C,
    input  logic             R,
    input  logic             CE,
    input  logic [WIDTH-1:0] I,
    output logic             O_RAW,
    output logic             O,
    output logic             VALID,
    output logic             RISE,
    output logic             FALL
);
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("logic_reduce_filt: WIDTH %0d out of range", WIDTH);
    end
    if (FILTER < 0 || FILTER > 255) begin : g_bad_filter
        $error("logic_reduce_filt: FILTER %0d out of range", FILTER);
    end

    logic             w_raw;
    logic             w_upd;
    logic             r_s;
    logic             r_o;
    logic [CNT_W-1:0] r_cnt;

    logic_reduce_core #(
        .WIDTH(WIDTH),
        .INV_MASK(INV_MASK),
        .MODE(MODE)
    ) u_core (
        .I(I),
        .O_RAW(w_raw)
    );

    // O takes the sample once it has differed for FILTER+1 consecutive CE cycles
    assign w_upd = CE && (r_s != r_o) && (r_cnt == CNT_W'(FILTER));

    always_ff @(posedge C) begin
        if (R) begin
            r_s   <= INIT;
            r_o   <= INIT;
            r_cnt <= '0;
        end else if (CE) begin
            r_s   <= w_raw;
            r_o   <= w_upd ? r_s : r_o;
            r_cnt <= (r_s == r_o || w_upd) ? '0 : r_cnt + 1'b1;
        end
    end

    assign O_RAW = w_raw;
    assign O     = r_o;
    assign VALID = r_s == r_o;

`ifdef LOGIC_REDUCE_FILT_EDGE_EN
    logic r_rise;
    logic r_fall;

    // pulses land in the same cycle O first shows its new value
    always_ff @(posedge C) begin
        if (R) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_upd && r_s;
            r_fall <= w_upd && !r_s;
        end
    end

    assign RISE = r_rise;
    assign FALL = r_fall;
`else
    assign RISE = 1'b0;
    assign FALL = 1'b0;
`endif
endmodule

// File: tb/tb_logic_reduce_filt.sv
// tb_logic_reduce_filt: randomized and directed checks of logic_reduce_filt against a window-based model.
module tb_logic_reduce_filt;
`ifdef LOGIC_REDUCE_FILT_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       C  = 1'b0;
    logic       R  = 1'b1;
    logic       CE = 1'b0;
    logic [7:0] I8 = 8'h00;

    logic o_raw[4], o[4], valid[4], rise[4], fall[4];
    logic mr[6], mo[6], mv[6], mrs[6], mf[6];

    int vectors = 0;
    int miscompares = 0;

    int W[4]   = '{5, 5, 5, 8};
    int MSK[4] = '{'h07, 'h07, 'h15, 'h00};
    int MD[4]  = '{3, 3, 0, 4};
    int FL[4]  = '{0, 3, 2, 0};
    bit IN[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};

    bit m_s[4], m_o[4], m_r[4], m_f[4];
    bit m_q[4][$];

    always #5 C = ~C;

    logic_reduce_filt u0 (
        .C(C), .R(R), .CE(CE), .I(I8[4:0]),
        .O_RAW(o_raw[0]), .O(o[0]), .VALID(valid[0]), .RISE(rise[0]), .FALL(fall[0])
    );
    logic_reduce_filt #(.FILTER(3)) u1 (
        .C(C), .R(R), .CE(CE), .I(I8[4:0]),
        .O_RAW(o_raw[1]), .O(o[1]), .VALID(valid[1]), .RISE(rise[1]), .FALL(fall[1])
    );
    logic_reduce_filt #(.FILTER(2), .INIT(1'b1), .MODE(0), .INV_MASK(5'b10101)) u2 (
        .C(C), .R(R), .CE(CE), .I(I8[4:0]),
        .O_RAW(o_raw[2]), .O(o[2]), .VALID(valid[2]), .RISE(rise[2]), .FALL(fall[2])
    );
    logic_reduce_filt #(.WIDTH(8), .MODE(4), .INV_MASK(8'h00)) u3 (
        .C(C), .R(R), .CE(CE), .I(I8),
        .O_RAW(o_raw[3]), .O(o[3]), .VALID(valid[3]), .RISE(rise[3]), .FALL(fall[3])
    );

    for (genvar m = 0; m < 6; m++) begin : g_mode
        logic_reduce_filt #(.WIDTH(6), .INV_MASK(6'b101100), .MODE(m)) u (
            .C(C), .R(R), .CE(CE), .I(I8[5:0]),
            .O_RAW(mr[m]), .O(mo[m]), .VALID(mv[m]), .RISE(mrs[m]), .FALL(mf[m])
        );
    end

    // reduction from the count of ones after inversion
    function automatic bit fred(int w, int mask, int mode, logic [7:0] i);
        logic [7:0] x;
        int n;
        x = (i ^ 8'(mask)) & 8'((1 << w) - 1);
        n = $countones(x);
        return ((mode < 2) ? (n == w) : (mode < 4) ? (n > 0) : n[0]) ^ mode[0];
    endfunction

    function automatic bit fraw(int k, logic [7:0] i);
        return fred(W[k], MSK[k], MD[k], i);
    endfunction

    // one clock: O follows the sample once the last FILTER+1 CE samples all differed from O
    task automatic step(input bit r, input bit ce, input logic [7:0] i);
        bit hit;
        R = r; CE = ce; I8 = i;
        @(posedge C);
        for (int k = 0; k < 4; k++) begin
            m_r[k] = 1'b0;
            m_f[k] = 1'b0;
            if (r) begin
                m_s[k] = IN[k];
                m_o[k] = IN[k];
                m_q[k].delete();
            end else if (ce) begin
                m_q[k].push_back(m_s[k] != m_o[k]);
                if (m_q[k].size() > 300) void'(m_q[k].pop_front());
                hit = m_q[k].size() >= FL[k] + 1;
                for (int j = 0; j <= FL[k] && hit; j++) hit = m_q[k][m_q[k].size() - 1 - j];
                if (hit) begin
                    m_o[k] = m_s[k];
                    m_r[k] = m_s[k];
                    m_f[k] = !m_s[k];
                    m_q[k].delete();
                end
                m_s[k] = fraw(k, i);
            end
        end
        #1;
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 8'hff);
        step(1'b1, 1'b0, 8'h00);
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (o[k] !== IN[k]) begin miscompares++; $display("FAIL reset_o[%0d] got %b exp %b", k, o[k], IN[k]); end
            vectors++;
            if (valid[k] !== 1'b1) begin miscompares++; $display("FAIL reset_valid[%0d] got %b exp 1", k, valid[k]); end
            vectors++;
            if (rise[k] !== 1'b0 || fall[k] !== 1'b0) begin miscompares++; $display("FAIL reset_edges[%0d] got %b%b exp 00", k, rise[k], fall[k]); end
        end
    endtask

    task automatic test_default_rise;
        step(1'b1, 1'b1, 8'h00);
        R = 1'b0; CE = 1'b1; I8 = 8'h07;
        #1;
        vectors++;
        if (o_raw[0] !== 1'b1) begin miscompares++; $display("FAIL dflt_raw got %b exp 1", o_raw[0]); end
        for (int c = 1; c <= 5; c++) begin
            step(1'b0, 1'b1, 8'h07);
            vectors++;
            if (o[0] !== (c >= 2)) begin miscompares++; $display("FAIL dflt_o cyc %0d got %b exp %b", c, o[0], c >= 2); end
            vectors++;
            if (rise[0] !== (EDGE && c == 2)) begin miscompares++; $display("FAIL dflt_rise cyc %0d got %b exp %b", c, rise[0], EDGE && c == 2); end
            vectors++;
            if (fall[0] !== 1'b0) begin miscompares++; $display("FAIL dflt_fall cyc %0d got %b exp 0", c, fall[0]); end
        end
    endtask

    task automatic test_glitch;
        bit saw_low = 1'b0;
        step(1'b1, 1'b1, 8'h00);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1, c < 3 ? 8'h07 : 8'h00);
            if (valid[1] === 1'b0) saw_low = 1'b1;
            vectors++;
            if (o[1] !== 1'b0) begin miscompares++; $display("FAIL glitch_o cyc %0d got %b exp 0", c, o[1]); end
            vectors++;
            if (rise[1] !== 1'b0) begin miscompares++; $display("FAIL glitch_rise cyc %0d got %b exp 0", c, rise[1]); end
        end
        vectors++;
        if (saw_low !== 1'b1) begin miscompares++; $display("FAIL glitch_valid_drop got %b exp 1", saw_low); end
        vectors++;
        if (valid[1] !== 1'b1) begin miscompares++; $display("FAIL glitch_valid_end got %b exp 1", valid[1]); end
    endtask

    task automatic test_ce_gap;
        step(1'b1, 1'b1, 8'h00);
        for (int c = 1; c <= 8; c++) begin
            step(1'b0, c != 3, 8'h07);
            vectors++;
            if (o[1] !== (c >= 6)) begin miscompares++; $display("FAIL cegap_o cyc %0d got %b exp %b", c, o[1], c >= 6); end
            vectors++;
            if (rise[1] !== (EDGE && c == 6)) begin miscompares++; $display("FAIL cegap_rise cyc %0d got %b exp %b", c, rise[1], EDGE && c == 6); end
        end
    endtask

    task automatic test_reset_midfilter;
        step(1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        vectors++;
        if (o[2] !== 1'b1 || valid[2] !== 1'b0) begin miscompares++; $display("FAIL midf_pending got o=%b v=%b exp o=1 v=0", o[2], valid[2]); end
        step(1'b1, 1'b1, 8'h00);
        vectors++;
        if (o[2] !== 1'b1 || valid[2] !== 1'b1) begin miscompares++; $display("FAIL midf_reset got o=%b v=%b exp o=1 v=1", o[2], valid[2]); end
        vectors++;
        if (rise[2] !== 1'b0 || fall[2] !== 1'b0) begin miscompares++; $display("FAIL midf_reset_edges got %b%b exp 00", rise[2], fall[2]); end
        for (int c = 1; c <= 5; c++) begin
            step(1'b0, 1'b1, 8'h00);
            vectors++;
            if (o[2] !== (c < 4)) begin miscompares++; $display("FAIL midf_o cyc %0d got %b exp %b", c, o[2], c < 4); end
            vectors++;
            if (fall[2] !== (EDGE && c == 4) || rise[2] !== 1'b0) begin miscompares++; $display("FAIL midf_edges cyc %0d got %b%b exp 0%b", c, rise[2], fall[2], EDGE && c == 4); end
        end
    endtask

    task automatic test_parity_sweep;
        step(1'b1, 1'b1, 8'h00);
        for (int v = 0; v < 256; v++) begin
            R = 1'b0; CE = 1'b1; I8 = v[7:0];
            #1;
            vectors++;
            if (o_raw[3] !== ($countones(v) % 2 == 1)) begin miscompares++; $display("FAIL parity_raw %0d got %b exp %b", v, o_raw[3], $countones(v) % 2 == 1); end
            step(1'b0, 1'b1, v[7:0]);
            if (v > 0) begin
                vectors++;
                if (o[3] !== ($countones(v - 1) % 2 == 1)) begin miscompares++; $display("FAIL parity_o %0d got %b exp %b", v, o[3], $countones(v - 1) % 2 == 1); end
            end
        end
    endtask

    task automatic test_modes;
        for (int n = 0; n < 40; n++) begin
            step(1'b0, 1'b1, 8'($urandom));
            for (int m = 0; m < 6; m++) begin
                vectors++;
                if (mr[m] !== fred(6, 'h2c, m, I8)) begin miscompares++; $display("FAIL mode%0d_raw I=%h got %b exp %b", m, I8, mr[m], fred(6, 'h2c, m, I8)); end
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] cur = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) cur = 8'($urandom);
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, cur);
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (o_raw[k] !== fraw(k, I8)) begin miscompares++; $display("FAIL rnd_raw[%0d] step %0d got %b exp %b", k, n, o_raw[k], fraw(k, I8)); end
                vectors++;
                if (o[k] !== m_o[k]) begin miscompares++; $display("FAIL rnd_o[%0d] step %0d got %b exp %b", k, n, o[k], m_o[k]); end
                vectors++;
                if (valid[k] !== (m_s[k] == m_o[k])) begin miscompares++; $display("FAIL rnd_valid[%0d] step %0d got %b exp %b", k, n, valid[k], m_s[k] == m_o[k]); end
                vectors++;
                if (rise[k] !== (EDGE && m_r[k])) begin miscompares++; $display("FAIL rnd_rise[%0d] step %0d got %b exp %b", k, n, rise[k], EDGE && m_r[k]); end
                vectors++;
                if (fall[k] !== (EDGE && m_f[k])) begin miscompares++; $display("FAIL rnd_fall[%0d] step %0d got %b exp %b", k, n, fall[k], EDGE && m_f[k]); end
                vectors++;
                if ((rise[k] & fall[k]) !== 1'b0) begin miscompares++; $display("FAIL rnd_both[%0d] step %0d got 1 exp 0", k, n); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_default_rise;
        test_glitch;
        test_ce_gap;
        test_reset_midfilter;
        test_parity_sweep;
        test_modes;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/logic_reduce_filt.md
LOGIC_REDUCE_FILT -- requirements
Module: logic_reduce_filt

Interface
REQ-001 SHALL have parameter WIDTH, default 5: number of inputs, legal 2..32.
REQ-002 SHALL have parameter INV_MASK, default 5'b00111: per-input inversion, bit k=1 inverts I[k] before reduction.
REQ-003 SHALL have parameter MODE, default 3: reduction 0=AND, 1=NAND, 2=OR, 3=NOR, 4=XOR, 5=XNOR; other values illegal (elaboration error).
REQ-004 SHALL have parameter FILTER, default 0: extra consecutive CE cycles a change must persist, legal 0..255.
REQ-005 SHALL have parameter INIT, default 1'b0: reset value of O.
REQ-006 SHALL have port C, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port R, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port CE, input, 1: clock enable.
REQ-009 SHALL have port I, input, WIDTH: data inputs.
REQ-010 SHALL have port O_RAW, output, 1: combinational reduction result, unregistered.
REQ-011 SHALL have port O, output, 1: filtered, registered result.
REQ-012 SHALL have port VALID, output, 1: high when sampled value equals O (no change pending).
REQ-013 SHALL have ports RISE and FALL, output, 1 each: one-cycle change pulses on O.

Function
REQ-014 SHALL compute O_RAW = MODE reduction over (I XOR INV_MASK); defaults give O_RAW = NOR(~I0,~I1,~I2,I3,I4).
REQ-015 SHALL register O_RAW into sample register S on every C edge with CE=1; S holds when CE=0.
REQ-016 SHALL hold a counter CNT of width 8; on CE=1 with S!=O: if CNT==FILTER then O<=S and CNT<=0, else CNT<=CNT+1.
REQ-017 SHALL clear CNT on CE=1 with S==O (glitch shorter than FILTER+1 sampled cycles discarded, count restarts).
REQ-018 SHALL hold O and CNT when CE=0; CE gaps do not reset the count.
REQ-019 SHALL give input-to-O latency of exactly FILTER+2 CE cycles for a stable input change; FILTER=0 gives 2 cycles.
REQ-020 SHALL drive VALID = (S==O) combinationally from registers.
REQ-021 SHALL assert RISE (FALL) for exactly one C cycle, the first cycle O shows 1 (0) after a change; deasserted next cycle regardless of CE.
REQ-022 SHALL never assert RISE and FALL together.

Reset
REQ-023 SHALL on R=1 set S<=INIT, O<=INIT, CNT<=0, RISE<=0, FALL<=0; R has priority over CE.
REQ-024 SHALL discard any pending count when R asserts mid-filter; no RISE/FALL generated by reset itself.
REQ-025 SHALL leave O_RAW unaffected by R.

Configuration
REQ-026 SHALL compile RISE/FALL generation only when macro LOGIC_REDUCE_FILT_EDGE_EN is defined; without it the ports exist and are tied 0, all other behaviour identical.

Structure
REQ-027 SHALL place MODE encodings (AND..XNOR) and the CNT width constant in shared package logic_reduce_pkg.
REQ-028 SHALL implement reduction as one combinational sub-module logic_reduce_core (I, INV_MASK, MODE -> O_RAW); filter and edge logic in top.

Verification
REQ-029 Defaults, R=1 one cycle, then I=5'b00111 held, CE=1 -> O_RAW=1 immediately, O=1 two cycles later, RISE one pulse.
REQ-030 FILTER=3, NOR default, O=0; 3-cycle O_RAW=1 glitch -> O stays 0, VALID drops then returns 1, no RISE.
REQ-031 FILTER=3, O_RAW=1 held 5 cycles with CE low in cycle 3 -> O rises on 6th cycle (FILTER+2 CE cycles), single RISE.
REQ-032 FILTER=2, change pending with CNT=1, R=1 -> O=INIT, CNT=0, VALID reflects S=INIT, no FALL/RISE.
REQ-033 WIDTH=8, MODE=4, INV_MASK=0, sweep I 0..255 -> O_RAW equals parity each vector; O follows 2 cycles later.
REQ-034 Build without LOGIC_REDUCE_FILT_EDGE_EN, repeat REQ-029 -> O identical, RISE=FALL=0 throughout.
